// File: rtl/myproject_mul_pkg.sv
// Shared constants and helpers for the pipelined saturating multiplier.
package myproject_mul_pkg;

  localparam int MIN_STAGE = 1;
  localparam int MAX_STAGE = 4;
  localparam int SAT_MAX_W = 128;

  typedef logic [SAT_MAX_W-1:0] wide_t;

  // Width of the exact product of a signed w0-bit operand and a w1-bit
  // operand extended by one bit so that it is always treated as signed.
  function automatic int full_prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  // Largest signed value representable in w bits: 2^(w-1)-1.
  function automatic wide_t sat_max(input int w);
    wide_t r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < w - 1) r[i] = 1'b1;
      else           r[i] = 1'b0;
    end
    return r;
  endfunction

  // Smallest signed value representable in w bits: -2^(w-1).
  function automatic wide_t sat_min(input int w);
    wide_t r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i >= w - 1) r[i] = 1'b1;
      else            r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mul_sat_trunc.sv
// Combinational reduction of the full product to the output width,
// either wrapping or clamping, with an overflow flag.
module myproject_mul_sat_trunc
  import myproject_mul_pkg::*;
#(
  parameter int PW       = 39,
  parameter int DW       = 38,
  parameter int SATURATE = 0
) (
  input  logic signed [PW-1:0] p,
  output logic [DW-1:0]        dout,
  output logic                 ovf
);

  if (DW >= PW) begin : g_wide
    // Output is wide enough for every product: plain sign extension.
    assign dout = DW'(p);
    assign ovf  = 1'b0;
  end else begin : g_narrow
    localparam wide_t MAXV = sat_max(DW);
    localparam wide_t MINV = sat_min(DW);

    logic [PW-DW:0] hi_s;
    logic           fits_s;

    assign hi_s = p[PW-1:DW-1];

    // The product fits when all bits above the output sign bit copy it.
    always_comb begin
      fits_s = 1'b0;
      if ((&hi_s) || !(|hi_s)) fits_s = 1'b1;
      else                     fits_s = 1'b0;
    end

    // Select wrapped, clamped-high or clamped-low result.
    always_comb begin
      dout = p[DW-1:0];
      ovf  = !fits_s;
      if (fits_s) begin
        dout = p[DW-1:0];
      end else if (SATURATE != 0) begin
        if (p[PW-1]) dout = MINV[DW-1:0];
        else         dout = MAXV[DW-1:0];
      end else begin
        dout = p[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with valid/ready flow control, global stall,
// wrap-or-saturate output reduction and a sticky overflow flag.
module myproject_mul_pipe_sat
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 6,
  parameter int DOUT_WIDTH  = 38,
  parameter int NUM_STAGE   = 2,
  parameter int DIN1_SIGNED = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int PW = full_prod_width(DIN0_WIDTH, DIN1_WIDTH);

  if (NUM_STAGE < MIN_STAGE || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
    $error("myproject_mul_pipe_sat: NUM_STAGE must be within 1..4");
  end

  logic signed [DIN0_WIDTH-1:0] a_s;
  logic signed [DIN1_WIDTH:0]   b_s;
  logic signed [PW-1:0]         prod_s;
  logic signed [PW-1:0]         fin_p_s;
  logic                         fin_v_s;
  logic [DOUT_WIDTH-1:0]        sat_dout_s;
  logic                         sat_ovf_s;
  logic                         advance_s;

  logic                         out_valid_r;
  logic [DOUT_WIDTH-1:0]        dout_r;
  logic                         out_ovf_r;
  logic                         sticky_r;

  assign a_s = din0;

  // Extend din1 by one bit so the multiply is always signed x signed.
  always_comb begin
    b_s = '0;
    if (DIN1_SIGNED != 0) b_s = {din1[DIN1_WIDTH-1], din1};
    else                  b_s = {1'b0, din1};
  end

  assign prod_s    = PW'(a_s) * PW'(b_s);
  assign advance_s = !out_valid_r || out_ready;
  assign in_ready  = advance_s;

  if (NUM_STAGE == 1) begin : g_one
    assign fin_p_s = prod_s;
    assign fin_v_s = in_valid;
  end else begin : g_multi
    logic signed [PW-1:0] p_r [NUM_STAGE-1];
    logic [NUM_STAGE-2:0] v_r;

    // Product and valid delay line; every stage freezes on a stall.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v_r <= '0;
        for (int k = 0; k < NUM_STAGE - 1; k++) p_r[k] <= '0;
      end else if (advance_s) begin
        p_r[0] <= prod_s;
        v_r[0] <= in_valid;
        for (int k = 1; k < NUM_STAGE - 1; k++) begin
          p_r[k] <= p_r[k-1];
          v_r[k] <= v_r[k-1];
        end
      end
    end

    assign fin_p_s = p_r[NUM_STAGE-2];
    assign fin_v_s = v_r[NUM_STAGE-2];
  end

  myproject_mul_sat_trunc #(
    .PW       (PW),
    .DW       (DOUT_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_trunc (
    .p    (fin_p_s),
    .dout (sat_dout_s),
    .ovf  (sat_ovf_s)
  );

  // Final registered stage holding the reduced result until it is taken.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_r <= 1'b0;
      dout_r      <= '0;
      out_ovf_r   <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= fin_v_s;
      dout_r      <= sat_dout_s;
      out_ovf_r   <= fin_v_s & sat_ovf_s;
    end
  end

  // Sticky overflow: a delivered overflowing result wins over a clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sticky_r <= 1'b0;
    end else if (out_valid_r && out_ready && out_ovf_r) begin
      sticky_r <= 1'b1;
    end else if (ovf_clr) begin
      sticky_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign dout       = dout_r;
  assign out_ovf    = out_ovf_r;
  assign ovf_sticky = sticky_r;

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Bench for myproject_mul_pipe_sat: four configurations share one stimulus
// stream; a reference model fills expected queues as operands are accepted.
module tb_myproject_mul_pipe_sat;

  typedef struct packed {
    logic        ovf;
    logic [63:0] d;
  } res_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;
  logic [31:0] din0;
  logic [5:0]  din1;

  logic        in_ready_a, in_ready_b, in_ready_c, in_ready_d;
  logic        out_valid_a, out_valid_b, out_valid_c, out_valid_d;
  logic [37:0] dout_a, dout_d;
  logic [15:0] dout_b, dout_c;
  logic        out_ovf_a, out_ovf_b, out_ovf_c, out_ovf_d;
  logic        ovf_sticky_a, ovf_sticky_b, ovf_sticky_c, ovf_sticky_d;

  res_t exp_q [4][$];
  res_t obs_q [4][$];
  res_t mon_r;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  // A: defaults
  myproject_mul_pipe_sat u_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .din0(din0), .din1(din1), .out_valid(out_valid_a), .out_ready(out_ready),
    .dout(dout_a), .out_ovf(out_ovf_a), .ovf_sticky(ovf_sticky_a), .ovf_clr(ovf_clr));

  // B: 16-bit saturating
  myproject_mul_pipe_sat #(.DOUT_WIDTH(16), .SATURATE(1)) u_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .din0(din0), .din1(din1), .out_valid(out_valid_b), .out_ready(out_ready),
    .dout(dout_b), .out_ovf(out_ovf_b), .ovf_sticky(ovf_sticky_b), .ovf_clr(ovf_clr));

  // C: 16-bit wrapping
  myproject_mul_pipe_sat #(.DOUT_WIDTH(16), .SATURATE(0)) u_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .din0(din0), .din1(din1), .out_valid(out_valid_c), .out_ready(out_ready),
    .dout(dout_c), .out_ovf(out_ovf_c), .ovf_sticky(ovf_sticky_c), .ovf_clr(ovf_clr));

  // D: signed din1
  myproject_mul_pipe_sat #(.DIN1_SIGNED(1)) u_d (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
    .din0(din0), .din1(din1), .out_valid(out_valid_d), .out_ready(out_ready),
    .dout(dout_d), .out_ovf(out_ovf_d), .ovf_sticky(ovf_sticky_d), .ovf_clr(ovf_clr));

  // Reference model: exact product, then wrap or clamp to dw bits.
  function automatic res_t model(input logic [31:0] a, input logic [5:0] b,
                                 input int dw, input bit sat, input bit s1);
    longint av, bv, p, mx, mn;
    res_t   r;
    av = longint'($signed(a));
    if (s1) bv = longint'($signed(b));
    else    bv = longint'({58'd0, b});
    p  = av * bv;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    r.ovf = (p > mx) || (p < mn);
    if (sat && r.ovf) r.d = (p > mx) ? mx : mn;
    else              r.d = (p <<< (64 - dw)) >>> (64 - dw);
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [5:0] b);
    exp_q[0].push_back(model(a, b, 38, 1'b0, 1'b0));
    exp_q[1].push_back(model(a, b, 16, 1'b1, 1'b0));
    exp_q[2].push_back(model(a, b, 16, 1'b0, 1'b0));
    exp_q[3].push_back(model(a, b, 38, 1'b0, 1'b1));
  endtask

  // Collect every delivered result (handshake on the next rising edge).
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (out_valid_a && out_ready) begin
        mon_r.ovf = out_ovf_a; mon_r.d = longint'($signed(dout_a)); obs_q[0].push_back(mon_r);
      end
      if (out_valid_b && out_ready) begin
        mon_r.ovf = out_ovf_b; mon_r.d = longint'($signed(dout_b)); obs_q[1].push_back(mon_r);
      end
      if (out_valid_c && out_ready) begin
        mon_r.ovf = out_ovf_c; mon_r.d = longint'($signed(dout_c)); obs_q[2].push_back(mon_r);
      end
      if (out_valid_d && out_ready) begin
        mon_r.ovf = out_ovf_d; mon_r.d = longint'($signed(dout_d)); obs_q[3].push_back(mon_r);
      end
    end
  end

  // Present one operand pair until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [5:0] b);
    bit done;
    done = 1'b0;
    din0 = a; din1 = b; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ap_clk);
      if (in_ready_a) begin
        push_exp(a, b);
        done = 1'b1;
      end
      @(posedge ap_clk); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: accepted=%0b required=1", done);
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; din0 = 32'd0; din1 = 6'd0;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid_a); end
    checks++; if (dout_a !== 38'd0) begin errors++; $display("FAIL rst_dout: got %h want 0", dout_a); end
    checks++; if (out_ovf_a !== 1'b0) begin errors++; $display("FAIL rst_out_ovf: got %b want 0", out_ovf_a); end
    checks++; if (ovf_sticky_b !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", ovf_sticky_b); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_latency;
    send(32'hFFFF_FFFF, 6'd63);
    in_valid = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b want 0", out_valid_a); end
    @(posedge ap_clk); #1;
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", out_valid_a); end
    checks++; if (dout_a !== 38'h3F_FFFF_FFC1) begin errors++; $display("FAIL lat_dout: got %h want 3fffffffc1", dout_a); end
    checks++; if (out_ovf_a !== 1'b0) begin errors++; $display("FAIL lat_ovf: got %b want 0", out_ovf_a); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_overflow;
    send(32'd1000, 6'd63);
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    checks++; if (dout_b !== 16'h7FFF) begin errors++; $display("FAIL sat_dout: got %h want 7fff", dout_b); end
    checks++; if (out_ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", out_ovf_b); end
    checks++; if (dout_c !== 16'hF618) begin errors++; $display("FAIL wrap_dout: got %h want f618", dout_c); end
    checks++; if (out_ovf_c !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b want 1", out_ovf_c); end
    checks++; if (dout_a !== 38'd63000) begin errors++; $display("FAIL wide_dout: got %h want f618", dout_a); end
    @(posedge ap_clk); #1;
    checks++; if (ovf_sticky_b !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", ovf_sticky_b); end
    checks++; if (ovf_sticky_a !== 1'b0) begin errors++; $display("FAIL wide_sticky: got %b want 0", ovf_sticky_a); end
  endtask

  task automatic test_signed;
    send(32'd5, 6'b111111);
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    checks++; if (dout_d !== 38'h3F_FFFF_FFFB) begin errors++; $display("FAIL signed_dout: got %h want 3ffffffffb", dout_d); end
    checks++; if (dout_a !== 38'd315) begin errors++; $display("FAIL unsigned_dout: got %0d want 315", dout_a); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_tab [6];
    logic [5:0]  b_tab [6];
    logic [37:0] held;
    bit          have_hold;
    int          sent, n0;
    a_tab = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd123456, 32'hFFFF_FFB3, 32'd0, 32'd777};
    b_tab = '{6'd63, 6'd63, 6'd17, 6'd40, 6'd63, 6'd33};
    sent = 0; have_hold = 1'b0; held = '0; n0 = obs_q[0].size();
    for (int c = 0; c < 80 && (sent < 6 || obs_q[0].size() < n0 + 6); c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (sent < 6) begin
        in_valid = 1'b1; din0 = a_tab[sent]; din1 = b_tab[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge ap_clk);
      if (!out_ready && out_valid_a) begin
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready_a); end
        if (have_hold) begin
          checks++;
          if (dout_a !== held) begin errors++; $display("FAIL stall_hold: got %h want %h", dout_a, held); end
        end else begin
          held = dout_a; have_hold = 1'b1;
        end
      end
      if (in_valid && in_ready_a) begin
        push_exp(din0, din1);
        sent++;
      end
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (!have_hold) begin errors++; $display("FAIL stall_seen: got 0 want 1"); end
    checks++; if (obs_q[0].size() != n0 + 6) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q[0].size() - n0, 6); end
  endtask

  task automatic test_reset_midflight;
    int n0;
    n0 = obs_q[0].size();
    out_ready = 1'b0;
    send(32'd11, 6'd3);
    send(32'd22, 6'd4);
    in_valid = 1'b0;
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid_a); end
    ap_rst_n = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid_a); end
    checks++; if (dout_a !== 38'd0) begin errors++; $display("FAIL mid_dout: got %h want 0", dout_a); end
    checks++; if (ovf_sticky_b !== 1'b0) begin errors++; $display("FAIL mid_sticky: got %b want 0", ovf_sticky_b); end
    for (int i = 0; i < 4; i++) begin
      void'(exp_q[i].pop_back());
      void'(exp_q[i].pop_back());
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1; out_ready = 1'b1;
    @(posedge ap_clk); #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready_a); end
    repeat (6) @(posedge ap_clk);
    #1;
    checks++; if (obs_q[0].size() != n0) begin errors++; $display("FAIL mid_stale: got %0d results want 0", obs_q[0].size() - n0); end
  endtask

  task automatic test_ovf_clr;
    send(32'd1000, 6'd63);
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    checks++; if (ovf_sticky_b !== 1'b1) begin errors++; $display("FAIL clr_pre_set: got %b want 1", ovf_sticky_b); end
    ovf_clr = 1'b1;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky_b !== 1'b0) begin errors++; $display("FAIL clr_clear: got %b want 0", ovf_sticky_b); end
    send(32'd1000, 6'd63);
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b1;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky_b !== 1'b1) begin errors++; $display("FAIL clr_priority_b: got %b want 1", ovf_sticky_b); end
    checks++; if (ovf_sticky_c !== 1'b1) begin errors++; $display("FAIL clr_priority_c: got %b want 1", ovf_sticky_c); end
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  task automatic test_scoreboard;
    res_t e, o;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exp_q[i].size() != obs_q[i].size()) begin
        errors++;
        $display("FAIL sb_count[%0d]: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size());
      end
      while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL sb_result[%0d]: got ovf=%b d=%h want ovf=%b d=%h", i, o.ovf, o.d, e.ovf, e.d);
        end
      end
    end
  endtask

  initial begin
    ap_rst_n = 1'b0;
    test_reset();
    test_latency();
    test_overflow();
    test_signed();
    test_back_to_back();
    test_reset_midflight();
    test_ovf_clr();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/myproject_mul_pipe_sat.md
MYPROJECT_MUL_PIPE_SAT -- requirements
Module: myproject_mul_pipe_sat

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 32, din0 width (always signed).
REQ-002 SHALL have parameter DIN1_WIDTH, default 6, din1 width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 38, result width.
REQ-004 SHALL have parameter NUM_STAGE, default 2, pipeline depth in cycles (legal range 1..4).
REQ-005 SHALL have parameter DIN1_SIGNED, default 0; 0 = din1 unsigned (zero-extended), 1 = din1 signed.
REQ-006 SHALL have parameter SATURATE, default 0; 0 = wrap (keep low DOUT_WIDTH bits), 1 = clamp to signed DOUT_WIDTH range.
REQ-007 SHALL have port ap_clk, input, 1, sole clock; reset is asynchronous and active-low.
REQ-008 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1, operand pair valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-011 SHALL have port din0, input, DIN0_WIDTH, signed operand.
REQ-012 SHALL have port din1, input, DIN1_WIDTH, operand (signedness per DIN1_SIGNED).
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-015 SHALL have port dout, output, DOUT_WIDTH, signed result.
REQ-016 SHALL have port out_ovf, output, 1, result lost information (wrapped or clamped); qualified by out_valid.
REQ-017 SHALL have port ovf_sticky, output, 1, OR of all out_ovf since reset or last clear.
REQ-018 SHALL have port ovf_clr, input, 1, synchronous clear of ovf_sticky.

Function
REQ-019 SHALL form full product P = din0 * ext(din1) at width DIN0_WIDTH+DIN1_WIDTH+1, ext = zero- or sign-extension per DIN1_SIGNED.
REQ-020 SHALL, with SATURATE=0, output dout = P[DOUT_WIDTH-1:0] and assert out_ovf when P is not representable as signed DOUT_WIDTH.
REQ-021 SHALL, with SATURATE=1, output 2^(DOUT_WIDTH-1)-1 when P > max, -2^(DOUT_WIDTH-1) when P < min, else P, with out_ovf=1 iff clamped.
REQ-022 SHALL produce out_ovf=0 always when DOUT_WIDTH >= full product width.
REQ-023 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, global stall).
REQ-024 SHALL transfer an input on in_valid && in_ready and present its result on dout exactly NUM_STAGE cycles later absent stalls.
REQ-025 SHALL freeze all stage data and valid bits in a cycle where advance=0; no result dropped or duplicated.
REQ-026 SHALL propagate bubbles: stage valid bits shift with zeros when in_valid=0.
REQ-027 SHALL hold dout/out_ovf stable while out_valid=1 and out_ready=0.
REQ-028 SHALL deliver results in input order.
REQ-029 SHALL set ovf_sticky on any cycle with out_valid && out_ready && out_ovf; ovf_clr SHALL clear it, with a same-cycle set taking priority.

Reset
REQ-030 SHALL on ap_rst_n=0 immediately clear all stage valid bits, out_valid=0, out_ovf=0, ovf_sticky=0, dout=0.
REQ-031 SHALL discard in-flight operands when reset is asserted mid-operation; first result after release comes only from post-reset inputs.
REQ-032 SHALL assert in_ready=1 in the first cycle after reset release.

Structure
REQ-033 SHALL place full-product width function and saturation-bound constants in shared package myproject_mul_pkg.
REQ-034 SHALL use one sub-module myproject_mul_sat_trunc (combinational P -> dout/out_ovf) at the final stage; multiply in stage 1, remaining stages are data+valid registers.
REQ-035 SHALL reject NUM_STAGE outside 1..4 at elaboration.

Verification
REQ-036 SHALL test defaults: din0=0xFFFFFFFF (-1), din1=63 -> dout=-63, out_ovf=0, out_valid 2 cycles after accept.
REQ-037 SHALL test DOUT_WIDTH=16, SATURATE=1: din0=1000, din1=63 -> dout=32767, out_ovf=1, ovf_sticky=1; SATURATE=0 -> dout=0xF618 (-2536), out_ovf=1.
REQ-038 SHALL test DIN1_SIGNED=1: din0=5, din1=6'b111111 -> dout=-5; DIN1_SIGNED=0 same inputs -> 315.
REQ-039 SHALL test backpressure: stream 6 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready=0 during stall, 6 results in order, none lost or repeated.
REQ-040 SHALL test reset mid-flight: 2 inputs accepted, ap_rst_n pulsed low -> out_valid=0 at once, no stale result after release.
REQ-041 SHALL test ovf_clr concurrent with overflowing handshake -> ovf_sticky remains 1.
